can_ahb_tx_master: RTL and testbench
====================================

// Module: can_ahb_tx_master
// PURPOSE
//  Upstream master port of one CAN node on the shared AHB ring. Queues outgoing CAN frame
//  descriptors from the node core in a small FIFO. For each frame it raises mHBUSREQ, waits for
//  mHGRANT from the round-robin arbitrator, then writes the frame as a 1-3 beat AHB write burst
//  into destination node window {BASE_HI|dest, TX_OFFSET}. There is one instance per node (m0..m7).
// PARAMETERS
//  FIFO_DEPTH  4        descriptor FIFO entries (power of 2, >=2)
//  NODE_ID     3'd0     source node number, packed into header word
//  BASE_HI     16'hF000 upper address half; dest is ORed into [2:0]
//  TX_OFFSET   16'h0000 lower address of beat 0; beat n at TX_OFFSET+4*n
//  RETRY_MAX   3        grant-loss restarts allowed before a frame is dropped
// PORTS
//  HCLK        in   1   bus clock, all state on rising edge
//  HRESETn     in   1   asynchronous active-low reset
//  req_valid   in   1   descriptor valid from node core
//  req_ready   out  1   = !fifo_full; push when req_valid&&req_ready
//  req_dest    in   3   destination node 0..7
//  req_id      in   11  CAN standard identifier
//  req_dlc     in   4   data length code; values >8 are treated as 8
//  req_data    in   64  payload; byte0 in [7:0]
//  mHBUSREQ    out  1   bus request to arbitrator
//  mHGRANT     in   1   grant from arbitrator
//  mHREADY     in   1   transfer ready; low = wait state
//  mHADDR      out  32  address phase
//  mHTRANS     out  2   00 IDLE, 10 NONSEQ, 11 SEQ
//  mHWRITE     out  1   1 during every non-IDLE address phase
//  mHWDATA     out  32  data phase, one cycle behind its address
//  tx_done     out  1   1-cycle pulse: frame fully written, entry popped
//  tx_err      out  1   1-cycle pulse: frame dropped after RETRY_MAX grant losses
// BEHAVIOUR
//  Reset (async, any state): FIFO emptied, FSM=IDLE, retry_cnt=0. All outputs 0, except
//   req_ready=1.
//  Beats: nb = 1 + (dlc_c>0) + (dlc_c>4), where dlc_c = min(dlc,8).
//   W0 = {NODE_ID,9'b0,dlc_c,5'b0,id}: [31:29] src, [19:16] dlc, [10:0] id.
//   W1 = data[31:0]; W2 = data[63:32].
//  FSM IDLE->REQ when FIFO is non-empty; mHBUSREQ=1 in REQ and in every bus state after it.
//  REQ->ADDR when mHGRANT=1 is sampled at the edge.
//  ADDR: beat0 NONSEQ, addr {BASE_HI|dest,TX_OFFSET}.
//  BURST: each cycle with mHREADY=1 advances one beat. Beat k>0 is SEQ at addr+4k, and
//   mHWDATA=W(k-1) is driven in the same cycle.
//  After the last address phase, DATA: HTRANS=IDLE and mHWDATA=W(nb-1).
//   mHREADY=1 in DATA -> pop, tx_done pulse next cycle, mHBUSREQ drops, retry_cnt=0,
//   next state IDLE (or REQ if the FIFO is still non-empty after the pop).
//  Latency: grant sampled at edge t -> beat0 address at cycle t+1; tx_done at cycle t+nb+2
//   when there are no waits.
//  mHREADY=0: hold mHADDR/mHTRANS/mHWDATA/beat counter unchanged.
//  Grant loss: mHGRANT=0 in ADDR/BURST/DATA ->
//   - next cycle: HTRANS=IDLE, beat counter=0, retry_cnt++;
//   - retry_cnt<RETRY_MAX: back to REQ, entry kept, frame restarts from W0;
//   - otherwise: pop, tx_err pulse, retry_cnt=0.
//  FIFO: req_ready=!full (no write-through when full). Push+pop in the same cycle leaves the
//   count unchanged. Head entry is stable while in flight; wrap via log2(FIFO_DEPTH) pointers.
//  tx_done and tx_err are never asserted together.
// STRUCTURE
//  can_ahb_pkg holds:
//   - htrans_e enum (IDLE/BUSY/NONSEQ/SEQ);
//   - can_desc_t packed struct {dest,id,dlc,data} (82 b);
//   - state enum {IDLE,REQ,ADDR,BURST,DATA,ABORT};
//   - beat-count function.
//  Sub-module can_desc_fifo (sync FIFO of can_desc_t, FIFO_DEPTH, async active-low reset).
//  Top level holds the FSM, beat/retry counters and the address/data pipeline registers.
// TESTING
//  1 Reset with HRESETn=0 mid-burst -> outputs 0 immediately, req_ready=1, FIFO empty.
//  2 Push dest=3,id=0x123,dlc=8,data=0x1122334455667788, NODE_ID=5, grant 2 cycles after
//    req -> addrs F003_0000/4/8 with NONSEQ,SEQ,SEQ;
//    WDATA A0080123, 55667788, 11223344; tx_done once.
//  3 dlc=0 -> single NONSEQ beat, W0 only; dlc=4 -> 2 beats; dlc=15 -> 3 beats, header
//    dlc field=8.
//  4 mHREADY=0 for 2 cycles on beat1 -> addr/HTRANS/WDATA held; tx_done delayed by
//    exactly 2 cycles.
//  5 Drop mHGRANT during beat1 -> IDLE next cycle, re-request, restart at W0.
//    4 consecutive drops (RETRY_MAX=3) -> tx_err pulse, entry popped.
//  6 Push 5 frames back-to-back with no grant -> req_ready=0 after 4.
//    Grant held -> 4 tx_done in order, 5th accepted after first pop.

Source files
------------

// File: rtl/can_ahb_pkg.sv
// Shared types and helpers for the CAN-node AHB transmit master: bus transfer codes,
// the queued frame descriptor, FSM states and the per-beat word builder.
package can_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef struct packed {
        logic [2:0]  dest;
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
    } can_desc_t;

    localparam int unsigned DESC_W = $bits(can_desc_t);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_BURST = 3'd3,
        ST_DATA  = 3'd4,
        ST_ABORT = 3'd5
    } state_e;

    function automatic logic [3:0] dlc_clamp(input logic [3:0] dlc);
        logic [3:0] c;
        if (dlc > 4'd8) begin
            c = 4'd8;
        end else begin
            c = dlc;
        end
        return c;
    endfunction

    // Header word always goes out; payload words only when they carry bytes.
    function automatic logic [1:0] beat_count(input logic [3:0] dlc);
        logic [3:0] c;
        logic [1:0] nb;
        c  = dlc_clamp(dlc);
        nb = 2'd1;
        if (c > 4'd0) begin
            nb = nb + 2'd1;
        end else begin
            nb = nb;
        end
        if (c > 4'd4) begin
            nb = nb + 2'd1;
        end else begin
            nb = nb;
        end
        return nb;
    endfunction

    function automatic logic [31:0] beat_word(input can_desc_t d, input logic [1:0] k,
                                              input logic [2:0] node);
        logic [31:0] w;
        case (k)
            2'd0:    w = {node, 9'b0, dlc_clamp(d.dlc), 5'b0, d.id};
            2'd1:    w = d.data[31:0];
            2'd2:    w = d.data[63:32];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/can_ahb_tx_master_fifo.sv
// Synchronous descriptor FIFO; the head entry stays put until the master pops it.
module can_desc_fifo
    import can_ahb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [DESC_W-1:0]             wdata_i,
    input  logic                          pop_i,
    output logic [DESC_W-1:0]             rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DESC_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push_s;
    logic              do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Pointers, occupancy and storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {DESC_W{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1'b1);
                2'b01:   count_q <= count_q - CNT_W'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/can_ahb_tx_master.sv
// AHB write master for one CAN node: queues frame descriptors and writes each one as a
// 1-3 beat burst into the destination node's receive window, retrying on grant loss.
module can_ahb_tx_master
    import can_ahb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [2:0]  NODE_ID    = 3'd0,
    parameter logic [15:0] BASE_HI    = 16'hF000,
    parameter logic [15:0] TX_OFFSET  = 16'h0000,
    parameter int unsigned RETRY_MAX  = 3
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_dest,
    input  logic [10:0] req_id,
    input  logic [3:0]  req_dlc,
    input  logic [63:0] req_data,
    output logic        mHBUSREQ,
    input  logic        mHGRANT,
    input  logic        mHREADY,
    output logic [31:0] mHADDR,
    output logic [1:0]  mHTRANS,
    output logic        mHWRITE,
    output logic [31:0] mHWDATA,
    output logic        tx_done,
    output logic        tx_err
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned RETRY_W = $clog2(RETRY_MAX + 2);

    state_e             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               busreq_q, busreq_d;
    logic [31:0]        haddr_q, haddr_d;
    htrans_e            htrans_q, htrans_d;
    logic               hwrite_q, hwrite_d;
    logic [31:0]        hwdata_q, hwdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               push_s;
    logic               pop_s;
    logic [DESC_W-1:0]  fifo_rdata_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CNT_W-1:0]   fifo_count_s;
    can_desc_t          head_s;
    logic [1:0]         nb_s;
    logic               more_s;

    assign req_ready = !fifo_full_s;
    assign push_s    = req_valid && !fifo_full_s;
    assign head_s    = can_desc_t'(fifo_rdata_s);
    assign nb_s      = beat_count(head_s.dlc);
    // A full FIFO refuses the push, so a push alongside a pop only happens below full.
    assign more_s    = (fifo_count_s > CNT_W'(1'b1)) || push_s;

    can_desc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (push_s),
        .wdata_i ({req_dest, req_id, req_dlc, req_data}),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Next state, counters, and the registered bus outputs for the next cycle
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        retry_d = retry_q;
        pop_s   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mHGRANT) begin
                    state_d = ST_ADDR;
                    beat_d  = 2'd0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ADDR, ST_BURST: begin
                if (!mHGRANT) begin
                    state_d = ST_ABORT;
                    beat_d  = 2'd0;
                    retry_d = retry_q + RETRY_W'(1'b1);
                end else if (mHREADY) begin
                    if ((beat_q + 2'd1) < nb_s) begin
                        state_d = ST_BURST;
                        beat_d  = beat_q + 2'd1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                if (!mHGRANT) begin
                    state_d = ST_ABORT;
                    beat_d  = 2'd0;
                    retry_d = retry_q + RETRY_W'(1'b1);
                end else if (mHREADY) begin
                    pop_s   = 1'b1;
                    done_d  = 1'b1;
                    beat_d  = 2'd0;
                    retry_d = {RETRY_W{1'b0}};
                    state_d = more_s ? ST_REQ : ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_ABORT: begin
                // retry_q already counts this loss, so exceeding the limit means exhausted.
                if (retry_q > RETRY_W'(RETRY_MAX)) begin
                    pop_s   = 1'b1;
                    err_d   = 1'b1;
                    retry_d = {RETRY_W{1'b0}};
                    state_d = more_s ? ST_REQ : ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = 2'd0;
                retry_d = {RETRY_W{1'b0}};
            end
        endcase

        busreq_d = 1'b0;
        htrans_d = HTRANS_IDLE;
        hwrite_d = 1'b0;
        haddr_d  = 32'h0000_0000;
        hwdata_d = 32'h0000_0000;
        case (state_d)
            ST_REQ, ST_ABORT: begin
                busreq_d = 1'b1;
            end
            ST_ADDR, ST_BURST: begin
                busreq_d = 1'b1;
                hwrite_d = 1'b1;
                htrans_d = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_SEQ;
                haddr_d  = {BASE_HI | {13'd0, head_s.dest},
                            TX_OFFSET + {12'd0, beat_d, 2'b00}};
                if (state_d == ST_BURST) begin
                    hwdata_d = beat_word(head_s, beat_d - 2'd1, NODE_ID);
                end else begin
                    hwdata_d = 32'h0000_0000;
                end
            end
            ST_DATA: begin
                busreq_d = 1'b1;
                hwdata_d = beat_word(head_s, nb_s - 2'd1, NODE_ID);
            end
            default: begin
                busreq_d = 1'b0;
            end
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            beat_q   <= 2'd0;
            retry_q  <= {RETRY_W{1'b0}};
            busreq_q <= 1'b0;
            haddr_q  <= 32'h0000_0000;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= 32'h0000_0000;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            retry_q  <= retry_d;
            busreq_q <= busreq_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign mHBUSREQ = busreq_q;
    assign mHADDR   = haddr_q;
    assign mHTRANS  = htrans_q;
    assign mHWRITE  = hwrite_q;
    assign mHWDATA  = hwdata_q;
    assign tx_done  = done_q;
    assign tx_err   = err_q;

endmodule

// File: tb/tb_can_ahb_tx_master.sv
// Directed bench for can_ahb_tx_master: table of single frames plus reset, grant-loss and
// back-pressure sequences, all against hand-computed bus traces.
module tb_can_ahb_tx_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_dest = 3'd0;
    logic [10:0] req_id = 11'd0;
    logic [3:0]  req_dlc = 4'd0;
    logic [63:0] req_data = 64'd0;
    logic        mHBUSREQ;
    logic        mHGRANT = 1'b0;
    logic        mHREADY = 1'b1;
    logic [31:0] mHADDR;
    logic [1:0]  mHTRANS;
    logic        mHWRITE;
    logic [31:0] mHWDATA;
    logic        tx_done;
    logic        tx_err;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    can_ahb_tx_master #(
        .FIFO_DEPTH (4),
        .NODE_ID    (3'd5),
        .BASE_HI    (16'hF000),
        .TX_OFFSET  (16'h0000),
        .RETRY_MAX  (3)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dest  (req_dest),
        .req_id    (req_id),
        .req_dlc   (req_dlc),
        .req_data  (req_data),
        .mHBUSREQ  (mHBUSREQ),
        .mHGRANT   (mHGRANT),
        .mHREADY   (mHREADY),
        .mHADDR    (mHADDR),
        .mHTRANS   (mHTRANS),
        .mHWRITE   (mHWRITE),
        .mHWDATA   (mHWDATA),
        .tx_done   (tx_done),
        .tx_err    (tx_err)
    );

    typedef struct {
        logic [2:0]  dest;
        logic [10:0] id;
        logic [3:0]  dlc;
        logic [63:0] data;
        int          nb;
        logic [31:0] w0;
        logic [31:0] addr;
        int          gdly;
        int          stall_at;
        int          stall_n;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic push(input logic [2:0] d, input logic [10:0] id, input logic [3:0] dlc,
                        input logic [63:0] data);
        req_valid = 1'b1;
        req_dest  = d;
        req_id    = id;
        req_dlc   = dlc;
        req_data  = data;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_busreq(input string nm);
        int n = 0;
        while (!mHBUSREQ && n < 20) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, mHBUSREQ}, 32'd1);
    endtask

    task automatic chk_beat(input string pfx, input int k, input logic [31:0] base,
                            input logic [31:0] w0, input logic [31:0] w1);
        chk($sformatf("%s_b%0d_htrans", pfx, k), {30'd0, mHTRANS}, (k == 0) ? 32'd2 : 32'd3);
        chk($sformatf("%s_b%0d_addr", pfx, k), mHADDR, base + 32'(4 * k));
        chk($sformatf("%s_b%0d_hwrite", pfx, k), {31'd0, mHWRITE}, 32'd1);
        if (k == 1) chk($sformatf("%s_b1_wdata", pfx), mHWDATA, w0);
        if (k == 2) chk($sformatf("%s_b2_wdata", pfx), mHWDATA, w1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] w[3];
        string pfx;
        pfx  = $sformatf("v%0d", idx);
        w[0] = v.w0;
        w[1] = v.data[31:0];
        w[2] = v.data[63:32];
        push(v.dest, v.id, v.dlc, v.data);
        wait_busreq({pfx, "_busreq"});
        for (int g = 0; g < v.gdly; g++) begin
            chk({pfx, "_nogrant_idle"}, {30'd0, mHTRANS}, 32'd0);
            tick();
        end
        mHGRANT = 1'b1;
        tick();
        for (int k = 0; k < v.nb; k++) begin
            chk_beat(pfx, k, v.addr, w[0], w[1]);
            if (k == v.stall_at) begin
                mHREADY = 1'b0;
                for (int s = 0; s < v.stall_n; s++) begin
                    tick();
                    chk_beat({pfx, "_hold"}, k, v.addr, w[0], w[1]);
                    chk({pfx, "_hold_nodone"}, {31'd0, tx_done}, 32'd0);
                end
                mHREADY = 1'b1;
            end
            tick();
        end
        chk({pfx, "_data_htrans"}, {30'd0, mHTRANS}, 32'd0);
        chk({pfx, "_data_wdata"}, mHWDATA, w[v.nb - 1]);
        chk({pfx, "_data_nodone"}, {31'd0, tx_done}, 32'd0);
        tick();
        chk({pfx, "_tx_done"}, {31'd0, tx_done}, 32'd1);
        chk({pfx, "_no_err"}, {31'd0, tx_err}, 32'd0);
        chk({pfx, "_busreq_drop"}, {31'd0, mHBUSREQ}, 32'd0);
        mHGRANT = 1'b0;
        tick();
        chk({pfx, "_done_once"}, {31'd0, tx_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_n;
        int ns_n;
        int first_done;
        int acc_cyc;
        logic [31:0] ea;

        vecs[0] = '{3'd3, 11'h123, 4'd8,  64'h1122334455667788, 3, 32'hA008_0123, 32'hF003_0000, 2, -1, 0};
        vecs[1] = '{3'd0, 11'h7FF, 4'd0,  64'hDEADBEEFCAFEF00D, 1, 32'hA000_07FF, 32'hF000_0000, 0, -1, 0};
        vecs[2] = '{3'd7, 11'h001, 4'd4,  64'h0000000012345678, 2, 32'hA004_0001, 32'hF007_0000, 1, -1, 0};
        vecs[3] = '{3'd5, 11'h2AA, 4'd15, 64'hA5A5A5A55A5A5A5A, 3, 32'hA008_02AA, 32'hF005_0000, 0, -1, 0};
        vecs[4] = '{3'd1, 11'h055, 4'd5,  64'h0F0E0D0C0B0A0908, 3, 32'hA005_0055, 32'hF001_0000, 3, -1, 0};
        vecs[5] = '{3'd2, 11'h400, 4'd1,  64'h00000000000000EE, 2, 32'hA001_0400, 32'hF002_0000, 0, -1, 0};
        vecs[6] = '{3'd3, 11'h123, 4'd8,  64'h1122334455667788, 3, 32'hA008_0123, 32'hF003_0000, 0, 1, 2};

        // Reset values while held in reset
        #3;
        chk("rst_busreq", {31'd0, mHBUSREQ}, 32'd0);
        chk("rst_htrans", {30'd0, mHTRANS}, 32'd0);
        chk("rst_haddr", mHADDR, 32'd0);
        chk("rst_hwrite", {31'd0, mHWRITE}, 32'd0);
        chk("rst_hwdata", mHWDATA, 32'd0);
        chk("rst_done_err", {30'd0, tx_done, tx_err}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        tick();
        HRESETn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Asynchronous reset in the middle of a burst, with a second frame queued
        push(3'd4, 11'h321, 4'd8, 64'h0123456789ABCDEF);
        push(3'd6, 11'h111, 4'd2, 64'h0000000000001234);
        wait_busreq("mr_busreq");
        mHGRANT = 1'b1;
        tick();
        tick();
        chk("mr_pre_seq", {30'd0, mHTRANS}, 32'd3);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("mr_busreq", {31'd0, mHBUSREQ}, 32'd0);
        chk("mr_htrans", {30'd0, mHTRANS}, 32'd0);
        chk("mr_haddr", mHADDR, 32'd0);
        chk("mr_hwdata", mHWDATA, 32'd0);
        chk("mr_hwrite", {31'd0, mHWRITE}, 32'd0);
        chk("mr_ready", {31'd0, req_ready}, 32'd1);
        HRESETn = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("mr_fifo_empty", {31'd0, mHBUSREQ}, 32'd0);
        end
        mHGRANT = 1'b0;

        // Grant loss on beat 1: three restarts, the fourth loss drops the frame
        push(3'd6, 11'h0AB, 4'd8, 64'h0102030405060708);
        wait_busreq("gl_busreq");
        mHGRANT = 1'b1;
        tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("gl%0d_nonseq", d), {30'd0, mHTRANS}, 32'd2);
            chk($sformatf("gl%0d_addr0", d), mHADDR, 32'hF006_0000);
            tick();
            chk($sformatf("gl%0d_seq", d), {30'd0, mHTRANS}, 32'd3);
            chk($sformatf("gl%0d_w0", d), mHWDATA, 32'hA008_00AB);
            mHGRANT = 1'b0;
            tick();
            chk($sformatf("gl%0d_idle", d), {30'd0, mHTRANS}, 32'd0);
            chk($sformatf("gl%0d_noerr", d), {31'd0, tx_err}, 32'd0);
            if (d < 3) begin
                tick();
                chk($sformatf("gl%0d_rereq", d), {31'd0, mHBUSREQ}, 32'd1);
                chk($sformatf("gl%0d_noerr2", d), {31'd0, tx_err}, 32'd0);
                mHGRANT = 1'b1;
                tick();
            end else begin
                tick();
                chk("gl_tx_err", {31'd0, tx_err}, 32'd1);
                chk("gl_no_done", {31'd0, tx_done}, 32'd0);
                tick();
                chk("gl_err_once", {31'd0, tx_err}, 32'd0);
                chk("gl_popped", {31'd0, mHBUSREQ}, 32'd0);
            end
        end

        // Five back-to-back frames without grant, then grant held
        mHGRANT = 1'b0;
        for (int f = 0; f < 4; f++) begin
            chk($sformatf("bp_ready%0d", f), {31'd0, req_ready}, 32'd1);
            req_valid = 1'b1;
            req_dest  = 3'(f);
            req_id    = 11'h100 + 11'(f);
            req_dlc   = 4'd0;
            req_data  = 64'd0;
            tick();
        end
        chk("bp_full", {31'd0, req_ready}, 32'd0);
        req_dest = 3'd4;
        req_id   = 11'h104;
        tick();
        chk("bp_still_full", {31'd0, req_ready}, 32'd0);
        mHGRANT    = 1'b1;
        done_n     = 0;
        ns_n       = 0;
        first_done = -1;
        acc_cyc    = -1;
        for (int c = 0; c < 100 && done_n < 5; c++) begin
            if (mHTRANS == 2'b10) begin
                ea = 32'hF000_0000 | (32'(ns_n) << 16);
                chk($sformatf("bp_order%0d", ns_n), mHADDR, ea);
                ns_n++;
            end
            if (tx_done) begin
                if (first_done < 0) first_done = c;
                done_n++;
            end
            if (first_done < 0) chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
            if (req_valid && req_ready) acc_cyc = c;
            tick();
            if (acc_cyc >= 0) req_valid = 1'b0;
        end
        chk("bp_all_done", 32'(done_n), 32'd5);
        chk("bp_all_started", 32'(ns_n), 32'd5);
        chk("bp_fifth_after_pop", 32'(acc_cyc), 32'(first_done));
        mHGRANT = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
